quad_position_ctrl: RTL and testbench
=====================================

Name: quad_position_ctrl

Overview:
Controller layered on quad_encoder. It programs the encoder's sampling divider and integrates pulse/direction into a signed position. It measures velocity over a programmable window, checks soft limits, and runs a homing sequence that drives motion requests until the index mark is found. It sits between quad_encoder and the motor-control register/command logic.

Parameters:
SAMPLING_WIDTH, 16, width of the sampling divider forwarded to quad_encoder
POS_WIDTH, 32, width of the signed position counter
VEL_WIDTH, 16, width of the signed velocity result
WINDOW_WIDTH, 24, width of the velocity window length and the homing timeout

Ports:
clock  in  1  single system clock, all logic on rising edge
srst  in  1  synchronous active-high reset
cfg_sampling  in  SAMPLING_WIDTH  new sampling divider value
cfg_load  in  1  loads cfg_sampling into sampling
sampling  out  SAMPLING_WIDTH  registered divider to quad_encoder
pulse  in  1  one-cycle count strobe from quad_encoder
direction  in  1  1 = increment, 0 = decrement; valid with pulse
index  in  1  encoder index level, already synchronous to clock
preset_valid  in  1  load position with preset_value
preset_value  in  POS_WIDTH  signed preset
position  out  POS_WIDTH  signed position
window  in  WINDOW_WIDTH  velocity window in clocks
velocity  out  VEL_WIDTH  signed counts per window
velocity_valid  out  1  one-cycle strobe on velocity update
limit_hi  in  POS_WIDTH  signed upper soft limit
limit_lo  in  POS_WIDTH  signed lower soft limit
limit_hit  out  1  position outside [limit_lo, limit_hi]
home_start  in  1  start homing (strobe)
home_dir  in  1  homing direction, sampled on home_start
home_abort  in  1  abort homing
home_timeout  in  WINDOW_WIDTH  max SEEK duration in clocks
move_req  out  1  request motion to motor driver
move_dir  out  1  requested direction
home_busy  out  1  homing in progress
home_done  out  1  one-cycle strobe: index found
home_error  out  1  one-cycle strobe: timeout or limit

Behaviour:
- Reset values: sampling = 1, position = 0, velocity = 0, velocity_valid = 0, limit_hit = 0, move_req = 0, move_dir = 0, home_busy = 0, home_done = 0, home_error = 0, FSM = IDLE, all internal counters 0, index_q = 0. Reset mid-operation aborts everything silently, with no done or error strobe.
- sampling: updates the cycle after cfg_load; otherwise holds.
- Position update, registered, takes effect the next cycle. Priority per cycle:
  - index rising edge in SEEK: position = 0.
  - else preset_valid: position = preset_value.
  - else pulse: position +1 if direction, else -1.
  - A pulse coinciding with a higher-priority event is discarded.
  - Arithmetic wraps modulo 2^POS_WIDTH (max+1 -> min).
- Index edge: index & ~index_q, where index_q is index registered.
- Velocity:
  - A window counter runs 0..W-1, with W = window, and window = 0 treated as 1.
  - A signed accumulator adds ±1 per pulse and saturates at +(2^(VEL_WIDTH-1)-1) and -2^(VEL_WIDTH-1).
  - On the cycle the counter equals W-1:
    - velocity <= accumulator plus that cycle's pulse, saturated.
    - velocity_valid = 1 on the following cycle, aligned with the new velocity.
    - Accumulator and counter restart at 0.
  - A change to window is sampled only at the window boundary.
  - Preset and index zeroing do not disturb the accumulator.
- limit_hit: registered signed compare of the current position register, so it is valid one cycle after position changes. If limit_lo > limit_hi, limit_hit = 1 always.
- Homing FSM:
  - IDLE: on home_start:
    - go to SEEK.
    - move_dir = home_dir, move_req = 1, home_busy = 1.
    - Timeout counter = 0.
  - SEEK: counter increments each cycle. Exits checked in this order:
    1. home_abort: go to IDLE, move_req = 0, home_busy = 0, no strobe.
    2. Index edge: position zeroed, go to DONE.
    3. limit_hit = 1, or counter == home_timeout with home_timeout != 0: go to FAIL.
    - home_timeout = 0 disables the timeout.
  - DONE: move_req = 0, home_done = 1 for one cycle, home_busy = 0, then IDLE.
  - FAIL: move_req = 0, home_error = 1 for one cycle, home_busy = 0, then IDLE.
  - home_start when not in IDLE is ignored.
  - home_abort in IDLE is ignored.
  - move_dir holds its last value after homing ends.

Test Plan:
- Reset, then 10 pulses with direction = 1 and 3 with direction = 0 -> position = 7. Hold position = 2^31-1 and pulse up -> position = -2^31.
- preset_valid with preset_value = 100, simultaneous with a pulse -> position = 100, pulse dropped. cfg_load with cfg_sampling = 5 -> sampling = 5 the next cycle; before that it reads 1.
- window = 100, one pulse up every 4 clocks -> velocity = 25 with velocity_valid every 100 cycles. Accumulate more than 32767 pulses up in one window -> velocity = 32767.
- home_start with home_dir = 0 -> move_req = 1, move_dir = 0, home_busy = 1. Index rising edge at cycle 50 -> position = 0, home_done one cycle later, move_req = 0.
- home_timeout = 30, no index -> home_error strobe 31 cycles after home_start, busy clears. Repeat with limit_hi = 5 while pulsing up -> home_error once limit_hit asserts.
- home_abort during SEEK -> IDLE, no strobe. A second home_start while busy is ignored. srst mid-SEEK -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/quad_position_ctrl.sv
// Position/velocity/homing controller layered on quad_encoder: integrates pulse/direction into
// a signed position, measures windowed velocity, checks soft limits and runs the homing sequence.
module quad_position_ctrl #(
   parameter int SAMPLING_WIDTH = 16,
   parameter int POS_WIDTH      = 32,
   parameter int VEL_WIDTH      = 16,
   parameter int WINDOW_WIDTH   = 24
) (
   input  logic                      clock,
   input  logic                      srst,
   input  logic [SAMPLING_WIDTH-1:0] cfg_sampling,
   input  logic                      cfg_load,
   output logic [SAMPLING_WIDTH-1:0] sampling,
   input  logic                      pulse,
   input  logic                      direction,
   input  logic                      index,
   input  logic                      preset_valid,
   input  logic [POS_WIDTH-1:0]      preset_value,
   output logic [POS_WIDTH-1:0]      position,
   input  logic [WINDOW_WIDTH-1:0]   window,
   output logic [VEL_WIDTH-1:0]      velocity,
   output logic                      velocity_valid,
   input  logic [POS_WIDTH-1:0]      limit_hi,
   input  logic [POS_WIDTH-1:0]      limit_lo,
   output logic                      limit_hit,
   input  logic                      home_start,
   input  logic                      home_dir,
   input  logic                      home_abort,
   input  logic [WINDOW_WIDTH-1:0]   home_timeout,
   output logic                      move_req,
   output logic                      move_dir,
   output logic                      home_busy,
   output logic                      home_done,
   output logic                      home_error
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEEK = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [1:0] ST_FAIL = 2'd3;

   localparam logic [SAMPLING_WIDTH-1:0] SAMP_ONE  = {{(SAMPLING_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [POS_WIDTH-1:0]      POS_ONE   = {{(POS_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WINDOW_WIDTH-1:0]   WIN_ONE   = {{(WINDOW_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [VEL_WIDTH:0]        VEL_PLUS  = {{VEL_WIDTH{1'b0}}, 1'b1};
   localparam logic [VEL_WIDTH:0]        VEL_MINUS = {(VEL_WIDTH+1){1'b1}};
   localparam logic [VEL_WIDTH-1:0]      VEL_MAX   = {1'b0, {(VEL_WIDTH-1){1'b1}}};
   localparam logic [VEL_WIDTH-1:0]      VEL_MIN   = {1'b1, {(VEL_WIDTH-1){1'b0}}};

   logic [SAMPLING_WIDTH-1:0] sampling_r;
   logic [POS_WIDTH-1:0]      position_r;
   logic [POS_WIDTH-1:0]      position_next_s;
   logic                      index_q_r;
   logic [WINDOW_WIDTH-1:0]   win_len_r;
   logic [WINDOW_WIDTH-1:0]   win_cnt_r;
   logic [WINDOW_WIDTH-1:0]   win_eff_s;
   logic [WINDOW_WIDTH-1:0]   tmo_cnt_r;
   logic [VEL_WIDTH-1:0]      acc_r;
   logic [VEL_WIDTH-1:0]      acc_sum_s;
   logic [VEL_WIDTH-1:0]      velocity_r;
   logic [VEL_WIDTH:0]        acc_wide_s;
   logic [VEL_WIDTH:0]        step_s;
   logic [1:0]                state_r;
   logic                      velocity_valid_r;
   logic                      limit_hit_r;
   logic                      move_req_r;
   logic                      move_dir_r;
   logic                      home_busy_r;
   logic                      home_done_r;
   logic                      home_error_r;
   logic                      index_edge_s;
   logic                      seek_edge_s;
   logic                      win_last_s;
   logic                      limit_next_s;

   // Next position, saturating accumulator sum, window boundary and limit compare.
   always_comb begin
      index_edge_s = index & ~index_q_r;
      seek_edge_s  = index_edge_s & (state_r == ST_SEEK);
      if (seek_edge_s) begin
         position_next_s = '0;
      end else if (preset_valid) begin
         position_next_s = preset_value;
      end else if (pulse) begin
         position_next_s = direction ? (position_r + POS_ONE) : (position_r - POS_ONE);
      end else begin
         position_next_s = position_r;
      end
      if (pulse) begin
         step_s = direction ? VEL_PLUS : VEL_MINUS;
      end else begin
         step_s = '0;
      end
      acc_wide_s = {acc_r[VEL_WIDTH-1], acc_r} + step_s;
      // One guard bit: top two bits differing means the sum left the VEL_WIDTH range.
      if (acc_wide_s[VEL_WIDTH] != acc_wide_s[VEL_WIDTH-1]) begin
         acc_sum_s = acc_wide_s[VEL_WIDTH] ? VEL_MIN : VEL_MAX;
      end else begin
         acc_sum_s = acc_wide_s[VEL_WIDTH-1:0];
      end
      win_eff_s    = (win_len_r == '0) ? WIN_ONE : win_len_r;
      win_last_s   = (win_cnt_r == (win_eff_s - WIN_ONE));
      limit_next_s = ($signed(limit_lo) > $signed(limit_hi))
                   | ($signed(position_r) > $signed(limit_hi))
                   | ($signed(position_r) < $signed(limit_lo));
   end

   // Divider, position, index history and soft-limit flag.
   always_ff @(posedge clock) begin
      if (srst) begin
         sampling_r  <= SAMP_ONE;
         position_r  <= '0;
         index_q_r   <= 1'b0;
         limit_hit_r <= 1'b0;
      end else begin
         if (cfg_load) begin
            sampling_r <= cfg_sampling;
         end
         position_r  <= position_next_s;
         index_q_r   <= index;
         limit_hit_r <= limit_next_s;
      end
   end

   // Velocity window; the window length is re-sampled only at a boundary (and at reset).
   always_ff @(posedge clock) begin
      if (srst) begin
         win_len_r        <= window;
         win_cnt_r        <= '0;
         acc_r            <= '0;
         velocity_r       <= '0;
         velocity_valid_r <= 1'b0;
      end else if (win_last_s) begin
         velocity_r       <= acc_sum_s;
         velocity_valid_r <= 1'b1;
         acc_r            <= '0;
         win_cnt_r        <= '0;
         win_len_r        <= window;
      end else begin
         acc_r            <= acc_sum_s;
         win_cnt_r        <= win_cnt_r + WIN_ONE;
         velocity_valid_r <= 1'b0;
      end
   end

   // Homing sequencer; strobes are raised on the transition into DONE/FAIL.
   always_ff @(posedge clock) begin
      if (srst) begin
         state_r      <= ST_IDLE;
         tmo_cnt_r    <= '0;
         move_req_r   <= 1'b0;
         move_dir_r   <= 1'b0;
         home_busy_r  <= 1'b0;
         home_done_r  <= 1'b0;
         home_error_r <= 1'b0;
      end else begin
         home_done_r  <= 1'b0;
         home_error_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (home_start) begin
                  state_r     <= ST_SEEK;
                  move_req_r  <= 1'b1;
                  move_dir_r  <= home_dir;
                  home_busy_r <= 1'b1;
                  tmo_cnt_r   <= '0;
               end
            end
            ST_SEEK: begin
               tmo_cnt_r <= tmo_cnt_r + WIN_ONE;
               if (home_abort) begin
                  state_r     <= ST_IDLE;
                  move_req_r  <= 1'b0;
                  home_busy_r <= 1'b0;
               end else if (index_edge_s) begin
                  state_r     <= ST_DONE;
                  move_req_r  <= 1'b0;
                  home_busy_r <= 1'b0;
                  home_done_r <= 1'b1;
               end else if (limit_hit_r
                            | ((tmo_cnt_r == home_timeout) & (home_timeout != '0))) begin
                  state_r      <= ST_FAIL;
                  move_req_r   <= 1'b0;
                  home_busy_r  <= 1'b0;
                  home_error_r <= 1'b1;
               end
            end
            ST_DONE: state_r <= ST_IDLE;
            ST_FAIL: state_r <= ST_IDLE;
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign sampling       = sampling_r;
   assign position       = position_r;
   assign velocity       = velocity_r;
   assign velocity_valid = velocity_valid_r;
   assign limit_hit      = limit_hit_r;
   assign move_req       = move_req_r;
   assign move_dir       = move_dir_r;
   assign home_busy      = home_busy_r;
   assign home_done      = home_done_r;
   assign home_error     = home_error_r;
endmodule

// File: tb/tb_quad_position_ctrl.sv
// Randomised scoreboard bench for quad_position_ctrl against a behavioural reference model.
module tb_quad_position_ctrl;
   logic        clock = 1'b0;
   logic        srst, cfg_load, pulse, direction, index, preset_valid;
   logic [15:0] cfg_sampling;
   logic [31:0] preset_value, limit_hi, limit_lo;
   logic [23:0] window, home_timeout;
   logic        home_start, home_dir, home_abort;
   logic [15:0] sampling, velocity;
   logic [31:0] position;
   logic        velocity_valid, limit_hit, move_req, move_dir, home_busy, home_done, home_error;

   quad_position_ctrl #(.SAMPLING_WIDTH(16), .POS_WIDTH(32), .VEL_WIDTH(16), .WINDOW_WIDTH(24)) dut (
      .clock(clock), .srst(srst), .cfg_sampling(cfg_sampling), .cfg_load(cfg_load),
      .sampling(sampling), .pulse(pulse), .direction(direction), .index(index),
      .preset_valid(preset_valid), .preset_value(preset_value), .position(position),
      .window(window), .velocity(velocity), .velocity_valid(velocity_valid),
      .limit_hi(limit_hi), .limit_lo(limit_lo), .limit_hit(limit_hit),
      .home_start(home_start), .home_dir(home_dir), .home_abort(home_abort),
      .home_timeout(home_timeout), .move_req(move_req), .move_dir(move_dir),
      .home_busy(home_busy), .home_done(home_done), .home_error(home_error));

   always #5 clock = ~clock;

   typedef struct { int cyc; int val; } ev_t;
   ev_t vel_q[$];
   ev_t home_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   bit  mon_en = 1'b0;

   // reference model state (reset values)
   logic [31:0] m_pos = 32'd0;
   logic [15:0] m_samp = 16'd1;
   bit m_lim = 1'b0, m_req = 1'b0, m_dir = 1'b0, m_busy = 1'b0, m_idx_prev = 1'b0;
   int m_hstate = 0;   // 0 idle, 1 seeking, 2 finishing
   int m_seek_t = 0, m_acc = 0, m_win_len = 0, m_win_pos = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      bit edge_i, was_seek, lim_prev;
      int step, sum, wlen;
      if (srst) begin
         m_pos = 32'd0; m_samp = 16'd1; m_lim = 1'b0; m_req = 1'b0; m_dir = 1'b0;
         m_busy = 1'b0; m_hstate = 0; m_seek_t = 0; m_idx_prev = 1'b0; m_acc = 0;
         m_win_len = int'(window); m_win_pos = 0;
         return;
      end
      edge_i     = index && !m_idx_prev;
      m_idx_prev = index;
      was_seek   = (m_hstate == 1);
      lim_prev   = m_lim;
      m_lim = ($signed(limit_lo) > $signed(limit_hi)) || ($signed(m_pos) > $signed(limit_hi))
              || ($signed(m_pos) < $signed(limit_lo));
      if (cfg_load) m_samp = cfg_sampling;
      step = pulse ? (direction ? 1 : -1) : 0;
      if (was_seek && edge_i) m_pos = 32'd0;
      else if (preset_valid)  m_pos = preset_value;
      else                    m_pos = m_pos + 32'(step);
      // velocity: net count over the window, clamped after every pulse
      sum = m_acc + step;
      if (sum > 32767)  sum = 32767;
      if (sum < -32768) sum = -32768;
      m_win_pos++;
      wlen = (m_win_len == 0) ? 1 : m_win_len;
      if (m_win_pos >= wlen) begin
         vel_q.push_back('{cyc, sum});
         m_acc = 0; m_win_pos = 0; m_win_len = int'(window);
      end else begin
         m_acc = sum;
      end
      case (m_hstate)
         0: if (home_start) begin
               m_hstate = 1; m_req = 1'b1; m_dir = home_dir; m_busy = 1'b1; m_seek_t = 0;
            end
         1: begin
               if (home_abort) begin
                  m_hstate = 0; m_req = 1'b0; m_busy = 1'b0;
               end else if (edge_i) begin
                  m_hstate = 2; m_req = 1'b0; m_busy = 1'b0; home_q.push_back('{cyc, 1});
               end else if (lim_prev || (home_timeout != 24'd0 && m_seek_t == int'(home_timeout))) begin
                  m_hstate = 2; m_req = 1'b0; m_busy = 1'b0; home_q.push_back('{cyc, 2});
               end
               m_seek_t++;
            end
         default: m_hstate = 0;
      endcase
   endtask

   initial begin
      forever begin
         @(posedge clock);
         cyc++;
         model_step();
      end
   end

   // monitor / scoreboard
   initial begin
      ev_t ev;
      forever begin
         @(negedge clock);
         if (mon_en) begin
            chk("position", longint'(position), longint'(m_pos));
            chk("sampling", longint'(sampling), longint'(m_samp));
            chk("limit_hit", longint'(limit_hit), longint'(m_lim));
            chk("move_req", longint'(move_req), longint'(m_req));
            chk("move_dir", longint'(move_dir), longint'(m_dir));
            chk("home_busy", longint'(home_busy), longint'(m_busy));
            if (vel_q.size() > 0 && vel_q[0].cyc == cyc) begin
               ev = vel_q.pop_front();
               chk("velocity_valid", longint'(velocity_valid), 64'sd1);
               chk("velocity", longint'($signed(velocity)), longint'(ev.val));
            end else begin
               chk("velocity_valid", longint'(velocity_valid), 64'sd0);
            end
            if (home_q.size() > 0 && home_q[0].cyc == cyc) begin
               ev = home_q.pop_front();
               chk("home_done", longint'(home_done), longint'(ev.val == 1));
               chk("home_error", longint'(home_error), longint'(ev.val == 2));
            end else begin
               chk("home_done", longint'(home_done), 64'sd0);
               chk("home_error", longint'(home_error), 64'sd0);
            end
         end
      end
   end

   task automatic cyc1();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      pulse = 1'b0; preset_valid = 1'b0; cfg_load = 1'b0;
      home_start = 1'b0; home_abort = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_position"}, longint'(position), 64'sd0);
      chk({tag, "_sampling"}, longint'(sampling), 64'sd1);
      chk({tag, "_velocity"}, longint'(velocity), 64'sd0);
      chk({tag, "_velocity_valid"}, longint'(velocity_valid), 64'sd0);
      chk({tag, "_limit_hit"}, longint'(limit_hit), 64'sd0);
      chk({tag, "_move_req"}, longint'(move_req), 64'sd0);
      chk({tag, "_move_dir"}, longint'(move_dir), 64'sd0);
      chk({tag, "_home_busy"}, longint'(home_busy), 64'sd0);
      chk({tag, "_home_done"}, longint'(home_done), 64'sd0);
      chk({tag, "_home_error"}, longint'(home_error), 64'sd0);
   endtask

   task automatic wide_limits();
      limit_hi = 32'h7FFF_FFFF;
      limit_lo = 32'h8000_0000;
   endtask

   initial begin
      int n, vv;
      idle_inputs();
      srst = 1'b1; direction = 1'b0; index = 1'b0; preset_value = 32'd0;
      cfg_sampling = 16'd0; window = 24'd100; home_dir = 1'b0; home_timeout = 24'd0;
      wide_limits();
      cyc1(); cyc1();
      check_reset_outputs("reset");
      srst = 1'b0;
      mon_en = 1'b1;

      // 10 up, 3 down -> 7
      for (int i = 0; i < 13; i++) begin
         pulse = 1'b1; direction = (i < 10); cyc1();
      end
      idle_inputs();
      chk("count_up_down", longint'(position), 64'sd7);

      // wrap max -> min
      preset_valid = 1'b1; preset_value = 32'h7FFF_FFFF; cyc1();
      idle_inputs(); pulse = 1'b1; direction = 1'b1; cyc1();
      idle_inputs();
      chk("wrap", longint'(position), 64'h8000_0000);

      // preset beats a coincident pulse
      preset_valid = 1'b1; preset_value = 32'd100; pulse = 1'b1; direction = 1'b1; cyc1();
      idle_inputs();
      chk("preset_drops_pulse", longint'(position), 64'sd100);

      // sampling divider load latency
      cfg_sampling = 16'd5; cfg_load = 1'b1;
      chk("sampling_before", longint'(sampling), 64'sd1);
      cyc1(); idle_inputs();
      chk("sampling_after", longint'(sampling), 64'sd5);

      // velocity: one pulse every 4 clocks over window 100
      vv = 0;
      for (int i = 0; i < 300; i++) begin
         pulse = (i % 4 == 0); direction = 1'b1; cyc1();
         if (velocity_valid) vv++;
      end
      idle_inputs();
      chk("velocity_25", longint'($signed(velocity)), 64'sd25);
      chk("velocity_strobes", longint'(vv), 64'sd3);

      // randomised mix, including homing, limits and window changes
      for (int i = 0; i < 1500; i++) begin
         idle_inputs();
         pulse = ($urandom_range(0, 2) != 0);
         direction = 1'($urandom_range(0, 1));
         index = 1'($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 40) == 0) begin
            preset_valid = 1'b1;
            preset_value = ($urandom_range(0, 5) == 0) ? 32'h7FFF_FFFC : 32'($urandom_range(0, 40)) - 32'd20;
         end
         if ($urandom_range(0, 60) == 0) begin
            cfg_load = 1'b1; cfg_sampling = 16'($urandom);
         end
         if (i % 80 == 0) begin
            limit_lo = 32'($urandom_range(0, 30)) - 32'd25;
            limit_hi = 32'($urandom_range(0, 30)) - 32'd5;
         end
         if (i % 150 == 0) window = 24'($urandom_range(0, 40));
         if ($urandom_range(0, 25) == 0) begin
            home_start = 1'b1; home_dir = 1'($urandom_range(0, 1));
            home_timeout = 24'($urandom_range(0, 40));
         end
         home_abort = ($urandom_range(0, 70) == 0);
         cyc1();
      end
      idle_inputs(); index = 1'b0;

      // directed homing: index found
      srst = 1'b1; window = 24'd100; wide_limits(); home_timeout = 24'd0; cyc1();
      srst = 1'b0;
      preset_valid = 1'b1; preset_value = 32'd1000; cyc1(); idle_inputs();
      home_start = 1'b1; home_dir = 1'b0; cyc1(); idle_inputs();
      chk("seek_move_req", longint'(move_req), 64'sd1);
      chk("seek_move_dir", longint'(move_dir), 64'sd0);
      chk("seek_busy", longint'(home_busy), 64'sd1);
      for (int i = 1; i < 50; i++) begin
         home_start = (i == 10); home_dir = 1'b1;
         cyc1();
      end
      idle_inputs();
      chk("restart_ignored_dir", longint'(move_dir), 64'sd0);
      index = 1'b1; cyc1(); index = 1'b0;
      chk("home_position_zero", longint'(position), 64'sd0);
      chk("home_done_strobe", longint'(home_done), 64'sd1);
      chk("home_done_req_off", longint'(move_req), 64'sd0);
      cyc1(); cyc1();

      // timeout of 30
      home_timeout = 24'd30; home_start = 1'b1; home_dir = 1'b1; cyc1(); idle_inputs();
      n = 0;
      while (n < 100) begin
         cyc1(); n++;
         if (home_error) break;
      end
      chk("timeout_latency", longint'(n), 64'sd31);
      chk("timeout_busy_clear", longint'(home_busy), 64'sd0);
      chk("move_dir_holds", longint'(move_dir), 64'sd1);
      cyc1(); cyc1();

      // soft-limit failure while moving up
      home_timeout = 24'd0; limit_hi = 32'd5;
      preset_valid = 1'b1; preset_value = 32'd0; cyc1(); idle_inputs(); cyc1();
      home_start = 1'b1; home_dir = 1'b1; cyc1(); idle_inputs();
      pulse = 1'b1; direction = 1'b1;
      n = 0;
      while (n < 40) begin
         cyc1(); n++;
         if (home_error) break;
      end
      idle_inputs();
      chk("limit_fail_latency", longint'(n), 64'sd8);
      chk("limit_fail_hit", longint'(limit_hit), 64'sd1);
      wide_limits(); cyc1(); cyc1();

      // abort during seek: no strobe
      home_start = 1'b1; home_dir = 1'b0; cyc1(); idle_inputs();
      repeat (5) cyc1();
      home_abort = 1'b1; cyc1(); idle_inputs();
      chk("abort_busy", longint'(home_busy), 64'sd0);
      chk("abort_req", longint'(move_req), 64'sd0);
      repeat (3) cyc1();

      // srst mid-seek
      cfg_sampling = 16'd9; cfg_load = 1'b1; cyc1(); idle_inputs();
      home_start = 1'b1; home_dir = 1'b1; cyc1(); idle_inputs();
      repeat (5) cyc1();
      srst = 1'b1; cyc1(); srst = 1'b0;
      check_reset_outputs("srst_mid_seek");

      // saturation over a long window
      srst = 1'b1; window = 24'd33000; cyc1(); srst = 1'b0;
      pulse = 1'b1; direction = 1'b1;
      repeat (33005) cyc1();
      idle_inputs();
      chk("velocity_saturate", longint'($signed(velocity)), 64'sd32767);
      cyc1(); cyc1();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
